// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register offsets and CTRL field layout.
package timer_pkg;

    localparam int unsigned TMR_BITS = 16;

    typedef enum logic [2:0] {
        TMR_CTRL     = 3'd0,
        TMR_PRESCALE = 3'd1,
        TMR_LOAD     = 3'd2,
        TMR_COUNT    = 3'd3,
        TMR_STATUS   = 3'd4,
        TMR_RSV5     = 3'd5,
        TMR_RSV6     = 3'd6,
        TMR_RSV7     = 3'd7
    } tmr_reg_e;

    // Packed so that bit 0 is EN, matching the software-visible CTRL layout.
    typedef struct packed {
        logic out_en;
        logic irq_en;
        logic mode;
        logic en;
    } tmr_ctrl_t;

endpackage

// File: rtl/timer_if.sv
// Peripheral bus between the memory controller and the timer, plus the timer's IRQ/TOUT lines.
interface timer_if
    import timer_pkg::*;
#(
    parameter int unsigned BITS = TMR_BITS
) ();

    logic [7:0]      ADDRESS;
    logic [BITS-1:0] DATA_IN;
    logic [BITS-1:0] DATA_OUT;
    logic            WRb;
    logic            IRQ;
    logic            TOUT;

    modport master (
        output ADDRESS,
        output DATA_IN,
        output WRb,
        input  DATA_OUT,
        input  IRQ,
        input  TOUT
    );

    modport slave (
        input  ADDRESS,
        input  DATA_IN,
        input  WRb,
        output DATA_OUT,
        output IRQ,
        output TOUT
    );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: counts up while enabled and emits a one-cycle TICK every DIV+1 cycles.
module timer_prescaler #(
    parameter int unsigned BITS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            RESTART,
    input  logic [BITS-1:0] DIV,
    output logic            TICK
);

    logic [BITS-1:0] pre_cnt_q, pre_cnt_d;

    always_comb begin
        TICK      = EN && (pre_cnt_q == DIV);
        pre_cnt_d = pre_cnt_q + BITS'(1);
        if (!EN || RESTART || TICK) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/timer.sv
// Memory-mapped down-counting timer: register file, reload/expiry logic and combinational read mux.
module timer
    import timer_pkg::*;
#(
    parameter int unsigned BITS     = TMR_BITS,
    parameter int unsigned CLK_FREQ = 10000000
) (
    input  logic    CLK,
    input  logic    RST,
    timer_if.slave  bus
);

    localparam int unsigned CTRL_W = $bits(tmr_ctrl_t);

    tmr_ctrl_t       ctrl_q, ctrl_d;
    logic [BITS-1:0] prescale_q, prescale_d;
    logic [BITS-1:0] load_q, load_d;
    logic [BITS-1:0] count_q, count_d;
    logic            exp_q, exp_d;
    logic            tout_q, tout_d;

    tmr_reg_e        sel;
    tmr_ctrl_t       wr_ctrl;
    logic            wr;
    logic            tick;
    logic            expire;
    logic            restart;
    logic [BITS-1:0] rdata;

    always_comb begin
        sel     = tmr_reg_e'(bus.ADDRESS[2:0]);
        wr      = ~bus.WRb;
        wr_ctrl = tmr_ctrl_t'(bus.DATA_IN[CTRL_W-1:0]);
        expire  = tick && (count_q == '0);
        restart = wr && (((sel == TMR_CTRL) && wr_ctrl.en && !ctrl_q.en) ||
                         (sel == TMR_PRESCALE));
    end

    timer_prescaler #(.BITS(BITS)) u_prescaler (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (ctrl_q.en),
        .RESTART (restart),
        .DIV     (prescale_q),
        .TICK    (tick)
    );

    // Bus writes are applied after the tick/expiry updates so a same-edge write overrides them,
    // except that a STATUS clear must not swallow a simultaneous expiry.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        count_d    = count_q;
        exp_d      = exp_q;
        tout_d     = tout_q;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - BITS'(1);
            end else if (!ctrl_q.mode) begin
                count_d = load_q;
            end
        end

        if (expire) begin
            exp_d = 1'b1;
            if (ctrl_q.out_en) begin
                tout_d = ~tout_q;
            end
            if (ctrl_q.mode) begin
                ctrl_d.en = 1'b0;
            end
        end

        if (wr) begin
            case (sel)
                TMR_CTRL:     ctrl_d     = wr_ctrl;
                TMR_PRESCALE: prescale_d = bus.DATA_IN;
                TMR_LOAD:     load_d     = bus.DATA_IN;
                TMR_COUNT:    count_d    = bus.DATA_IN;
                TMR_STATUS: begin
                    if (bus.DATA_IN[0] && !expire) begin
                        exp_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            load_q     <= '0;
            count_q    <= '0;
            exp_q      <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            load_q     <= load_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
            tout_q     <= tout_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            TMR_CTRL:     rdata[CTRL_W-1:0] = ctrl_q;
            TMR_PRESCALE: rdata             = prescale_q;
            TMR_LOAD:     rdata             = load_q;
            TMR_COUNT:    rdata             = count_q;
            TMR_STATUS:   rdata[0]          = exp_q;
            default:      rdata             = '0;
        endcase
    end

    assign bus.DATA_OUT = rdata;
    assign bus.IRQ      = exp_q & ctrl_q.irq_en;
    assign bus.TOUT     = tout_q;

    // Upper address bits alias; CLK_FREQ is documentation only.
    logic unused_ok;
    assign unused_ok = ^{bus.ADDRESS[7:3], CLK_FREQ[0]};

endmodule

// File: tb/tb_timer.sv
// Directed and randomized checks of the timer against an arithmetic model of its timing rules.
module tb_timer;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic        tout_base = 1'b0;

    timer_if #(.BITS(16)) bus ();

    timer #(.BITS(16), .CLK_FREQ(10000000)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int unsigned e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.ADDRESS = a;
        bus.DATA_IN = d;
        bus.WRb     = 1'b0;
        @(posedge clk);
        #1;
        bus.WRb     = 1'b1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        bus.ADDRESS = a;
        #1;
        d = bus.DATA_OUT;
    endtask

    // Count and number of expiries n cycles after the enabling edge, from the timing rules.
    function automatic void model(input int p, input int c, input int l, input bit oneshot,
                                  input int n, output int cnt, output int nexp);
        int ticks;
        ticks = n / (p + 1);
        if (ticks <= c) begin
            cnt  = c - ticks;
            nexp = 0;
        end else if (oneshot) begin
            cnt  = 0;
            nexp = 1;
        end else begin
            nexp = 1 + (ticks - (c + 1)) / (l + 1);
            cnt  = l - (ticks - (c + 1)) % (l + 1);
        end
    endfunction

    initial begin
        logic [15:0]  d;
        int unsigned  k;
        logic [15:0]  exp_rsv [8];
        logic [7:0]   a;

        bus.ADDRESS = '0;
        bus.DATA_IN = '0;
        bus.WRb     = 1'b1;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        rd(8'h00, d); chk("reset_ctrl", d, 16'h0000);
        chk("reset_irq", {15'b0, bus.IRQ}, 16'h0000);

        // Reset mid-run
        wr(8'h01, 16'd0); wr(8'h03, 16'd1); wr(8'h02, 16'd1); wr(8'h00, 16'h000F);
        k = cyc;
        wait_to(k + 5);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            a[2:0] = 3'(i);
            rd(a, d);
            chk("midrun_reset_read", d, 16'h0000);
        end
        chk("midrun_reset_irq", {15'b0, bus.IRQ}, 16'h0000);
        chk("midrun_reset_tout", {15'b0, bus.TOUT}, 16'h0000);
        k = cyc;
        wait_to(k + 100);
        rd(8'h04, d); chk("idle_after_reset_status", d, 16'h0000);
        rd(8'h03, d); chk("idle_after_reset_count", d, 16'h0000);

        // Periodic mode with IRQ
        wr(8'h01, 16'd0); wr(8'h03, 16'd3); wr(8'h02, 16'd3); wr(8'h00, 16'h0005);
        k = cyc;
        wait_to(k + 3); chk("periodic_irq_before", {15'b0, bus.IRQ}, 16'h0000);
        wait_to(k + 4); chk("periodic_irq_first", {15'b0, bus.IRQ}, 16'h0001);
        wr(8'h04, 16'h0001);
        chk("periodic_irq_cleared", {15'b0, bus.IRQ}, 16'h0000);
        wait_to(k + 7); chk("periodic_irq_before2", {15'b0, bus.IRQ}, 16'h0000);
        wait_to(k + 8); chk("periodic_irq_second", {15'b0, bus.IRQ}, 16'h0001);
        wr(8'h00, 16'h0000); wr(8'h04, 16'h0001);
        rd(8'h04, d); chk("periodic_status_clear", d, 16'h0000);

        // Prescaled square wave on TOUT
        wr(8'h01, 16'd9); wr(8'h02, 16'd0); wr(8'h03, 16'd0); wr(8'h00, 16'h0009);
        k = cyc;
        for (int j = 1; j <= 4; j++) begin
            wait_to(k + 10 * j - 1);
            chk("tout_before_toggle", {15'b0, bus.TOUT}, 16'((j - 1) & 1));
            wait_to(k + 10 * j);
            chk("tout_after_toggle", {15'b0, bus.TOUT}, 16'(j & 1));
            rd(8'h03, d); chk("tout_count_zero", d, 16'h0000);
        end
        wr(8'h00, 16'h0000); wr(8'h04, 16'h0001);

        // One-shot
        wr(8'h01, 16'd1); wr(8'h03, 16'd5); wr(8'h00, 16'h0003);
        k = cyc;
        wait_to(k + 11); rd(8'h04, d); chk("oneshot_not_yet", d, 16'h0000);
        wait_to(k + 12); rd(8'h04, d); chk("oneshot_expired", d, 16'h0001);
        rd(8'h00, d); chk("oneshot_ctrl_en_cleared", d, 16'h0002);
        rd(8'h03, d); chk("oneshot_count_zero", d, 16'h0000);
        wr(8'h04, 16'h0001);
        wait_to(k + 113);
        rd(8'h04, d); chk("oneshot_no_rearm", d, 16'h0000);
        rd(8'h00, d); chk("oneshot_ctrl_hold", d, 16'h0002);

        // Collisions: STATUS clear vs expiry, COUNT write vs tick
        wr(8'h01, 16'd1); wr(8'h03, 16'd2); wr(8'h02, 16'd2); wr(8'h00, 16'h0001);
        k = cyc;
        wait_to(k + 5);
        wr(8'h04, 16'h0001);
        rd(8'h04, d); chk("collide_status_set_wins", d, 16'h0001);
        wr(8'h04, 16'h0001);
        rd(8'h04, d); chk("collide_status_cleared", d, 16'h0000);
        wr(8'h03, 16'd7);
        rd(8'h03, d); chk("collide_count_write_wins", d, 16'd7);
        wait_to(k + 9);  rd(8'h03, d); chk("collide_count_hold", d, 16'd7);
        wait_to(k + 10); rd(8'h03, d); chk("collide_count_next_tick", d, 16'd6);
        wr(8'h00, 16'h0000); wr(8'h04, 16'h0001);

        // CTRL write vs one-shot auto-clear
        wr(8'h01, 16'd0); wr(8'h03, 16'd0); wr(8'h00, 16'h0003);
        wr(8'h00, 16'h0003);
        rd(8'h00, d); chk("collide_ctrl_write_wins", d, 16'h0003);
        rd(8'h04, d); chk("collide_ctrl_expired", d, 16'h0001);
        wr(8'h00, 16'h0000); wr(8'h04, 16'h0001);

        // Reserved offsets and aliases
        wr(8'h01, 16'd4); wr(8'h02, 16'd9); wr(8'h03, 16'd11);
        wr(8'h05, 16'hFFFF); wr(8'h06, 16'hFFFF); wr(8'h07, 16'hFFFF);
        exp_rsv = '{16'd0, 16'd4, 16'd9, 16'd11, 16'd0, 16'd0, 16'd0, 16'd0};
        for (int i = 0; i < 8; i++) begin
            rd(8'(i), d);
            chk("reserved_sweep", d, exp_rsv[i]);
        end
        rd(8'hFA, d); chk("alias_load", d, 16'd9);
        rd(8'h59, d); chk("alias_prescale", d, 16'd4);

        // Randomized runs with bus read traffic
        for (int t = 0; t < 6; t++) begin
            int p, c, l, cnt, nexp;
            bit ms;
            p  = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 6));
            l  = int'($urandom_range(0, 6));
            ms = 1'($urandom_range(0, 1));
            wr(8'h04, 16'h0001);
            wr(8'h01, 16'(p)); wr(8'h03, 16'(c)); wr(8'h02, 16'(l));
            wr(8'h00, 16'h000D | (16'(ms) << 1));
            k = cyc;
            for (int n = 1; n <= 50; n++) begin
                wait_to(k + n);
                bus.ADDRESS = 8'($urandom);
                #1;
                model(p, c, l, ms, n, cnt, nexp);
                chk("rand_irq", {15'b0, bus.IRQ}, 16'(nexp > 0));
                chk("rand_tout", {15'b0, bus.TOUT}, {15'b0, tout_base ^ nexp[0]});
                a = 8'($urandom);
                a[2:0] = 3'd3;
                rd(a, d);
                chk("rand_count", d, 16'(cnt));
            end
            wr(8'h00, 16'h0000);
            model(p, c, l, ms, 51, cnt, nexp);
            tout_base = tout_base ^ nexp[0];
            chk("rand_tout_after_stop", {15'b0, bus.TOUT}, {15'b0, tout_base});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
